// File: rtl/fifo_sync_ext.sv
// Single-clock FIFO with selectable registered / first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, occupancy output, flush and sticky errors.
module fifo_sync_ext #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             clr_err,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [$clog2(DEPTH):0] level,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [AW:0] DEPTH_LVL = LW'(DEPTH);
  localparam logic [AW:0] AF_LVL    = LW'(AF_LEVEL);
  localparam logic [AW:0] AE_LVL    = LW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q,  level_d;
  logic          ovf_q,    ovf_d;
  logic          udf_q,    udf_d;

  logic wr_ok;
  logic rd_ok;

  // Status outputs are pure decodes of the registered occupancy.
  assign empty        = (level_q == '0);
  assign full         = (level_q == DEPTH_LVL);
  assign almost_empty = (level_q <= AE_LVL);
  assign almost_full  = (level_q >= AF_LVL);
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // Acceptance uses the registered flags only, so a write into a full FIFO is
  // dropped even when a read frees a slot on the same edge.
  assign wr_ok = wr_en & ~full  & ~flush;
  assign rd_ok = rd_en & ~empty & ~flush;

  // NOTE: every always_comb target gets a default first, otherwise an
  // untaken branch leaves it holding its old value and a latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end

    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    // Set events are evaluated after the clear so they win a same-cycle tie.
    if (wr_en & full & ~flush) begin
      ovf_d = 1'b1;
    end
    if (rd_en & empty & ~flush) begin
      udf_d = 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // NOTE: the storage array has no reset; contents are only observable once
  // written, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is shown as soon as it exists; popping advances to the next.
    assign dout = empty ? '0 : mem_q[rd_ptr_q];
  end else begin : g_registered
    logic [WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (flush) begin
        dout_d = '0;
      end else if (rd_ok) begin
        dout_d = mem_q[rd_ptr_q];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
      end else begin
        dout_q <= dout_d;
      end
    end

    assign dout = dout_q;
  end

endmodule
